vmask_scan: RTL
===============

Name: vmask_scan

Overview:
- Streaming mask-reduction unit in the vALU; successor to the fixed 8-bit mask popcount.
- Consumes a mask register as a sequence of REQ_DATA_WIDTH-bit beats framed by in_start/in_end.
- Returns one scalar per operation: vcpop (population count) or vfirst (index of the first set element).
- Adds: parametrised beat width, optional v0 masking, vfirst mode, and mid-stream restart.

Parameters:
- REQ_DATA_WIDTH, 64: mask bits per beat; power of 2, minimum 8.
- RESP_DATA_WIDTH, 64: result width; must be at least log2(maximum VL)+1.
- SEW_WIDTH, 2: width of in_sew.
- OPSEL_WIDTH, 3: width of in_opSel.
- FIRST_ENABLE, 1: 1 = vfirst supported; 0 = vfirst opSel is treated as vcpop.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_m0  in  REQ_DATA_WIDTH  source mask beat
- in_mask  in  REQ_DATA_WIDTH  v0 mask beat, same bit alignment as in_m0
- in_mask_en  in  1  1 = AND in_m0 with in_mask (vm=0)
- in_valid  in  1  beat valid; qualifies in_start and in_end
- in_sew  in  SEW_WIDTH  element stride selector
- in_opSel  in  OPSEL_WIDTH  3'b000 = vcpop, 3'b001 = vfirst, others reserved
- in_start  in  1  first beat of an operation
- in_end  in  1  last beat of an operation
- out_vec  out  RESP_DATA_WIDTH  result; 0 when out_valid = 0
- out_valid  out  1  one-cycle result strobe

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset state: all pipeline registers, accumulators, out_vec and out_valid are 0. A reset mid-operation discards the operation; no out_valid is produced for it.
- Beat acceptance: a beat is accepted when in_valid = 1. There is no backpressure. in_start, in_end, in_sew and in_opSel are sampled only on accepted beats. in_sew and in_opSel are held constant within an operation; the values sampled on the start beat govern the operation.
- Element selection:
  - Stride S = 1 << in_sew.
  - Bit i of a beat is an element iff i % S == 0.
  - Elements per beat E = REQ_DATA_WIDTH >> in_sew.
  - Effective bit = in_m0[i] & (in_mask_en ? in_mask[i] : 1).
- Pipeline:
  - Stage 0 registers the effective masked beat plus its control bits.
  - Stage 1 registers the per-beat popcount and the per-beat first local element index (lowest selected set bit i, index = i >> in_sew), with a found flag.
  - Stage 2 updates the accumulators.
- Accumulators: cnt (running count), base (element offset of the current beat), first and found.
  - A start beat loads cnt = beat count, base = E, first = beat local index, found = beat found.
  - Other beats: cnt += beat count; base += E; if !found && beat found then first = base + local index and found = 1.
  - All arithmetic is modulo 2^RESP_DATA_WIDTH.
- Output: out_valid = 1 exactly 3 cycles after the accepted in_end beat, for one cycle.
  - vcpop: out_vec = cnt.
  - vfirst: out_vec = found ? first : all-ones (-1).
  - Reserved opSel: out_valid still pulses and out_vec = 0.
- Framing cases:
  - Start and end on the same beat is a single-beat operation.
  - Back-to-back operations are allowed: the next start beat may immediately follow an end beat, and results pulse in consecutive cycles.
  - Bubbles (in_valid = 0) inside an operation do not alter the accumulators.
  - in_start without a prior end restarts accumulation; the old operation produces no result.
  - in_end with no prior start accumulates from the reset/zero state.
- Sustained throughput is one beat per cycle.

Test Plan:
- vcpop, sew=0, W=64, 2 beats: in_m0 = 64'hFF, then 64'h1 with end -> out_vec = 9, out_valid 3 cycles after the end beat.
- vcpop, sew=3, single beat (start+end): in_m0 = 64'hFFFF_FFFF_FFFF_FFFF -> 8. Same beat with in_mask_en = 1 and in_mask = 64'h0101 -> 2.
- vfirst, sew=1, 2 beats: beat0 = 0, beat1 = 64'h10 (bit 4) -> 32 + 2 = 34. All-zero mask -> all-ones.
- Back-to-back single-beat ops 64'h3 (vcpop) then 64'h8 (vfirst, sew=0) -> out_valid two consecutive cycles, values 2 then 3. Insert bubbles mid-op -> result unchanged.
- Restart: start beat 64'hF, then a new start 64'h1 with end -> single result of 1. Reset asserted one cycle after an end beat -> no out_valid, outputs 0.

Source files
------------

// File: rtl/vmask_scan.sv
// Streaming mask reduction: vcpop / vfirst over a mask register delivered as framed beats.
// Three register stages: masked beat, per-beat reduction, running accumulators plus result.
module vmask_scan #(
  parameter int REQ_DATA_WIDTH  = 64,
  parameter int RESP_DATA_WIDTH = 64,
  parameter int SEW_WIDTH       = 2,
  parameter int OPSEL_WIDTH     = 3,
  parameter int FIRST_ENABLE    = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [REQ_DATA_WIDTH-1:0]  in_m0,
  input  logic [REQ_DATA_WIDTH-1:0]  in_mask,
  input  logic                       in_mask_en,
  input  logic                       in_valid,
  input  logic [SEW_WIDTH-1:0]       in_sew,
  input  logic [OPSEL_WIDTH-1:0]     in_opSel,
  input  logic                       in_start,
  input  logic                       in_end,
  output logic [RESP_DATA_WIDTH-1:0] out_vec,
  output logic                       out_valid
);

  typedef enum logic [1:0] {
    KIND_CPOP  = 2'd0,
    KIND_FIRST = 2'd1,
    KIND_RSVD  = 2'd2
  } op_kind_e;

  typedef logic [RESP_DATA_WIDTH-1:0] resp_t;

  // One bit per element position for a given stride 1 << sew.
  function automatic logic [REQ_DATA_WIDTH-1:0] elem_sel(input logic [SEW_WIDTH-1:0] sew);
    logic [REQ_DATA_WIDTH-1:0] sel;
    sel = '0;
    for (int i = 0; i < REQ_DATA_WIDTH; i++) begin
      sel[i] = ((i & ((1 << sew) - 1)) == 0);
    end
    return sel;
  endfunction

  op_kind_e in_kind;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    in_kind = KIND_RSVD;
    if (in_opSel == OPSEL_WIDTH'(0)) begin
      in_kind = KIND_CPOP;
    end else if (in_opSel == OPSEL_WIDTH'(1)) begin
      in_kind = (FIRST_ENABLE != 0) ? KIND_FIRST : KIND_CPOP;
    end
  end

  // Stage 0: effective masked beat and framing.
  logic                      s0_valid, s0_start, s0_end;
  logic [SEW_WIDTH-1:0]      s0_sew;
  op_kind_e                  s0_kind;
  logic [REQ_DATA_WIDTH-1:0] s0_bits;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      s0_valid <= 1'b0;
      s0_start <= 1'b0;
      s0_end   <= 1'b0;
      s0_sew   <= '0;
      s0_kind  <= KIND_CPOP;
      s0_bits  <= '0;
    end else begin
      s0_valid <= in_valid;
      s0_start <= in_valid & in_start;
      s0_end   <= in_valid & in_end;
      s0_sew   <= in_sew;
      s0_kind  <= in_kind;
      s0_bits  <= in_m0 & (in_mask_en ? in_mask : '1);
    end
  end

  // Stage 1: per-beat popcount and lowest selected set element.
  logic [REQ_DATA_WIDTH-1:0] sel_bits;
  resp_t                     beat_cnt, beat_idx;
  logic                      beat_found;

  always_comb begin
    sel_bits   = s0_bits & elem_sel(s0_sew);
    beat_cnt   = '0;
    beat_idx   = '0;
    beat_found = 1'b0;
    // Scanning downward leaves the lowest set element in beat_idx.
    for (int i = REQ_DATA_WIDTH - 1; i >= 0; i--) begin
      if (sel_bits[i]) begin
        beat_cnt   = beat_cnt + RESP_DATA_WIDTH'(1);
        beat_idx   = RESP_DATA_WIDTH'(i) >> s0_sew;
        beat_found = 1'b1;
      end
    end
  end

  logic     s1_valid, s1_start, s1_end, s1_found;
  op_kind_e s1_kind;
  resp_t    s1_cnt, s1_idx, s1_elems;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_start <= 1'b0;
      s1_end   <= 1'b0;
      s1_found <= 1'b0;
      s1_kind  <= KIND_CPOP;
      s1_cnt   <= '0;
      s1_idx   <= '0;
      s1_elems <= '0;
    end else begin
      s1_valid <= s0_valid;
      s1_start <= s0_start;
      s1_end   <= s0_end;
      s1_found <= beat_found;
      s1_kind  <= s0_kind;
      s1_cnt   <= beat_cnt;
      s1_idx   <= beat_idx;
      s1_elems <= RESP_DATA_WIDTH'(REQ_DATA_WIDTH) >> s0_sew;
    end
  end

  // Stage 2: accumulators; the result is formed from their next values.
  resp_t    cnt_q, base_q, first_q, cnt_n, base_n, first_n, result;
  logic     found_q, found_n;
  op_kind_e kind_q, kind_n;

  always_comb begin
    cnt_n   = cnt_q;
    base_n  = base_q;
    first_n = first_q;
    found_n = found_q;
    kind_n  = kind_q;
    if (s1_valid) begin
      if (s1_start) begin
        cnt_n   = s1_cnt;
        base_n  = s1_elems;
        first_n = s1_idx;
        found_n = s1_found;
        kind_n  = s1_kind;
      end else begin
        cnt_n  = cnt_q + s1_cnt;
        base_n = base_q + s1_elems;
        if (!found_q && s1_found) begin
          first_n = base_q + s1_idx;
          found_n = 1'b1;
        end
      end
    end
    case (kind_n)
      KIND_CPOP:  result = cnt_n;
      KIND_FIRST: result = found_n ? first_n : '1;
      default:    result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      base_q    <= '0;
      first_q   <= '0;
      found_q   <= 1'b0;
      kind_q    <= KIND_CPOP;
      out_valid <= 1'b0;
      out_vec   <= '0;
    end else begin
      out_valid <= s1_valid & s1_end;
      out_vec   <= (s1_valid && s1_end) ? result : '0;
      // A finished operation returns the accumulators to the zero state, so an
      // end beat without a start accumulates from scratch.
      if (s1_valid && s1_end) begin
        cnt_q   <= '0;
        base_q  <= '0;
        first_q <= '0;
        found_q <= 1'b0;
        kind_q  <= KIND_CPOP;
      end else begin
        cnt_q   <= cnt_n;
        base_q  <= base_n;
        first_q <= first_n;
        found_q <= found_n;
        kind_q  <= kind_n;
      end
    end
  end

endmodule
